// File: rtl/fmap_stream_source.sv
//-----------------------------------------------------------------------------
// fmap_stream_source
//
// Reads one IMG_H x IMG_W feature map from a synchronous single-port RAM in
// raster order and streams it to the convolution line-buffer chain as a
// registered (dout, dout_vld) pixel stream with row and frame markers.
// Downstream has no back-pressure; issue pacing is controlled by ce only.
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle frame start request (ignored while busy)
//   ce         in   issue enable; no new pixel is issued while low
//   busy       out  high while a frame is in progress (RUN, DRAIN, DONE)
//   done       out  one-cycle pulse once the final pixel has been emitted
//   mem_rd_en  out  RAM read strobe
//   mem_addr   out  RAM read address
//   mem_rdata  in   RAM read data, valid the cycle after mem_rd_en
//   dout       out  pixel data (registered, holds when dout_vld is low)
//   dout_vld   out  pixel valid, one cycle per pixel
//   row_last   out  marks the last pixel of each row
//   frame_last out  marks the final pixel of the frame
//
// Optional feature: define FMAP_PAD_EN to surround the frame with a PAD-wide
// zero border. Border pixels do not touch the RAM but travel through the same
// two-stage pipeline so stream timing stays uniform.
//-----------------------------------------------------------------------------
module fmap_stream_source #(
  parameter int WIDTH  = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10,
  parameter int PAD    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ce,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_vld,
  output logic              row_last,
  output logic              frame_last
);

`ifdef FMAP_PAD_EN
  localparam int PAD_EFF = PAD;
`else
  // Without the pad feature the border width collapses to zero.
  localparam int PAD_EFF = 0 * PAD;
`endif

  localparam int FRAME_W = IMG_W + 2 * PAD_EFF;
  localparam int FRAME_H = IMG_H + 2 * PAD_EFF;
  localparam int COL_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int ROW_W   = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(FRAME_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(FRAME_H - 1);

`ifdef FMAP_PAD_EN
  // First and one-past-last column/row of the real image inside the frame.
  localparam logic [COL_W-1:0] COL_LO = COL_W'(PAD);
  localparam logic [COL_W-1:0] COL_HI = COL_W'(IMG_W + PAD);
  localparam logic [ROW_W-1:0] ROW_LO = ROW_W'(PAD);
  localparam logic [ROW_W-1:0] ROW_HI = ROW_W'(IMG_H + PAD);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;
  logic              drain_cnt;

  logic issue;
  logic rd_issue;
  logic col_wrap;
  logic last_pix;

  logic s1_vld;
  logic s1_row_last;
  logic s1_frame_last;

`ifdef FMAP_PAD_EN
  logic border;
  logic s1_border;
`endif

  // Issue decode: one frame position per RUN cycle with ce high.
  always_comb begin
    issue    = (state == S_RUN) && ce;
    col_wrap = (col == COL_MAX);
    last_pix = col_wrap && (row == ROW_MAX);
`ifdef FMAP_PAD_EN
    border   = (row < ROW_LO) || (row >= ROW_HI) ||
               (col < COL_LO) || (col >= COL_HI);
    rd_issue = issue && !border;
`else
    rd_issue = issue;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and combinational outputs. The RAM strobe comes straight from
  // the issue decode so the RAM sees the address in the issue cycle itself.
  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    mem_rd_en  = rd_issue;
    mem_addr   = addr;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (issue && last_pix) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Raster counters and the linear RAM address. The address only advances on
  // real reads, so border positions never consume RAM locations.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      addr      <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end
      if (issue) begin
        if (col_wrap) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (rd_issue) begin
        addr <= addr + 1'b1;
      end
      // Two DRAIN cycles cover the RAM read stage and the output register.
      if (state == S_DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
      end else begin
        drain_cnt <= 1'b0;
      end
    end
  end

  // Two-stage pixel pipeline: stage 1 waits for the RAM data, stage 2 is the
  // output register. Markers ride along with the valid bit so they can never
  // appear without a pixel. Reset clears both stages, which drops any reads
  // still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld        <= 1'b0;
      s1_row_last   <= 1'b0;
      s1_frame_last <= 1'b0;
`ifdef FMAP_PAD_EN
      s1_border     <= 1'b0;
`endif
      dout          <= '0;
      dout_vld      <= 1'b0;
      row_last      <= 1'b0;
      frame_last    <= 1'b0;
      done          <= 1'b0;
    end else begin
      s1_vld        <= issue;
      s1_row_last   <= issue && col_wrap;
      s1_frame_last <= issue && last_pix;
`ifdef FMAP_PAD_EN
      s1_border     <= issue && border;
      if (s1_vld) begin
        dout <= s1_border ? '0 : mem_rdata;
      end
`else
      if (s1_vld) begin
        dout <= mem_rdata;
      end
`endif
      dout_vld      <= s1_vld;
      row_last      <= s1_row_last;
      frame_last    <= s1_frame_last;
      // Registering done places it in the first IDLE cycle, so a start
      // presented alongside done is accepted as the next frame.
      done          <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_fmap_stream_source.sv
//-----------------------------------------------------------------------------
// tb_fmap_stream_source
//
// Directed bench for fmap_stream_source on a 4x3 map with RAM[a] = a + 0x10.
// A negedge monitor logs every pixel, done pulse and RAM read with its cycle
// stamp; each scenario task then compares the log against expected values
// computed from the frame geometry.
//-----------------------------------------------------------------------------
module tb_fmap_stream_source;

  localparam int WIDTH  = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int ADDR_W = 4;
  localparam int PAD    = 1;

`ifdef FMAP_PAD_EN
  localparam int FW = IMG_W + 2 * PAD;
  localparam int FH = IMG_H + 2 * PAD;
`else
  localparam int FW = IMG_W;
  localparam int FH = IMG_H;
`endif
  localparam int NPIX     = FW * FH;
  localparam int NREAD    = IMG_W * IMG_H;
  // Relative cycle stamps: start sampled at edge 0, cycle k carries stamp k-1.
  localparam int FIRST_REL = 2;
  localparam int DONE_REL  = NPIX + 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic              ce;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_rdata;
  logic [WIDTH-1:0]  dout;
  logic              dout_vld;
  logic              row_last;
  logic              frame_last;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [WIDTH-1:0] ram [0:(1<<ADDR_W)-1];

  int pix_q[$];
  int rl_q[$];
  int fl_q[$];
  int pcyc_q[$];
  int done_q[$];
  int addr_q[$];
  int flag_q[$];

  fmap_stream_source #(
    .WIDTH (WIDTH),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .PAD   (PAD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ce        (ce),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .row_last  (row_last),
    .frame_last(frame_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM model with one cycle of read latency.
  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = WIDTH'(a + 16);
  end
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (dout_vld) begin
      pix_q.push_back(int'(dout));
      rl_q.push_back(int'(row_last));
      fl_q.push_back(int'(frame_last));
      pcyc_q.push_back(cyc);
    end else if (row_last || frame_last) begin
      flag_q.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
    if (mem_rd_en) addr_q.push_back(int'(mem_addr));
  end

  // Reference model of the stream.
  function automatic int exp_pix(input int i);
    int r;
    int c;
    r = i / FW;
    c = i % FW;
`ifdef FMAP_PAD_EN
    if (r < PAD || r >= IMG_H + PAD || c < PAD || c >= IMG_W + PAD) return 0;
    return 16 + (r - PAD) * IMG_W + (c - PAD);
`else
    return 16 + r * IMG_W + c;
`endif
  endfunction

  function automatic int exp_rl(input int i);
    return ((i % FW) == FW - 1) ? 1 : 0;
  endfunction

  function automatic int exp_fl(input int i);
    return (i == NPIX - 1) ? 1 : 0;
  endfunction

  task automatic clear_logs();
    pix_q.delete();
    rl_q.delete();
    fl_q.delete();
    pcyc_q.delete();
    done_q.delete();
    addr_q.delete();
    flag_q.delete();
  endtask

  task automatic start_frame(output int c0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    ce    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_rd_en, dout_vld, row_last, frame_last} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got busy=%b done=%b rd=%b vld=%b rl=%b fl=%b, expected all 0",
               busy, done, mem_rd_en, dout_vld, row_last, frame_last);
    end
    checks++;
    if (dout !== '0 || mem_addr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got dout=%0h addr=%0h, expected 0 and 0", dout, mem_addr);
    end
    clear_logs();
    repeat (5) @(negedge clk);
    checks++;
    if (done_q.size() !== 0 || pix_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL idle_quiet: got done=%0d pixels=%0d, expected 0 and 0", done_q.size(), pix_q.size());
    end
  endtask

  task automatic test_basic();
    int c0;
    bit ok;
    clear_logs();
    ce = 1'b1;
    start_frame(c0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_busy: got %b, expected 1", busy);
    end
    wait_done(1, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL basic_timeout: got no done, expected done within 200 cycles");
    end
    repeat (4) @(negedge clk);
    checks++;
    if (pix_q.size() !== NPIX) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d pixels, expected %0d", pix_q.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < pix_q.size(); i++) begin
      checks++;
      if (pix_q[i] !== exp_pix(i) || rl_q[i] !== exp_rl(i) || fl_q[i] !== exp_fl(i) ||
          (pcyc_q[i] - c0) !== FIRST_REL + i) begin
        errors++;
        $display("[TB] FAIL basic_pix[%0d]: got data=%0h rl=%0d fl=%0d t=%0d, expected data=%0h rl=%0d fl=%0d t=%0d",
                 i, pix_q[i], rl_q[i], fl_q[i], pcyc_q[i] - c0, exp_pix(i), exp_rl(i), exp_fl(i), FIRST_REL + i);
      end
    end
    checks++;
    if (done_q.size() !== 1 || (done_q[0] - c0) !== DONE_REL) begin
      errors++;
      $display("[TB] FAIL basic_done: got %0d pulses first at t=%0d, expected 1 at t=%0d",
               done_q.size(), done_q.size() > 0 ? done_q[0] - c0 : -1, DONE_REL);
    end
    checks++;
    if (addr_q.size() !== NREAD) begin
      errors++;
      $display("[TB] FAIL basic_reads: got %0d reads, expected %0d", addr_q.size(), NREAD);
    end
    for (int k = 0; k < NREAD && k < addr_q.size(); k++) begin
      checks++;
      if (addr_q[k] !== k) begin
        errors++;
        $display("[TB] FAIL basic_addr[%0d]: got %0d, expected %0d", k, addr_q[k], k);
      end
    end
    checks++;
    if (flag_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_idle: got stray markers=%0d busy=%b, expected 0 and 0", flag_q.size(), busy);
    end
  endtask

  task automatic test_ce_gap();
    int c0;
    int erel;
    bit ok;
    clear_logs();
    ce = 1'b1;
    start_frame(c0);
    repeat (5) @(posedge clk);
    #1;
    ce = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ce = 1'b1;
    wait_done(1, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL gap_timeout: got no done, expected done within 200 cycles");
    end
    repeat (4) @(negedge clk);
    checks++;
    if (pix_q.size() !== NPIX) begin
      errors++;
      $display("[TB] FAIL gap_count: got %0d pixels, expected %0d", pix_q.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < pix_q.size(); i++) begin
      erel = (i < 5) ? FIRST_REL + i : FIRST_REL + 2 + i;
      checks++;
      if (pix_q[i] !== exp_pix(i) || rl_q[i] !== exp_rl(i) || fl_q[i] !== exp_fl(i) ||
          (pcyc_q[i] - c0) !== erel) begin
        errors++;
        $display("[TB] FAIL gap_pix[%0d]: got data=%0h rl=%0d fl=%0d t=%0d, expected data=%0h rl=%0d fl=%0d t=%0d",
                 i, pix_q[i], rl_q[i], fl_q[i], pcyc_q[i] - c0, exp_pix(i), exp_rl(i), exp_fl(i), erel);
      end
    end
    checks++;
    if (done_q.size() !== 1 || (done_q[0] - c0) !== DONE_REL + 2) begin
      errors++;
      $display("[TB] FAIL gap_done: got %0d pulses first at t=%0d, expected 1 at t=%0d",
               done_q.size(), done_q.size() > 0 ? done_q[0] - c0 : -1, DONE_REL + 2);
    end
    checks++;
    if (addr_q.size() !== NREAD) begin
      errors++;
      $display("[TB] FAIL gap_reads: got %0d reads, expected %0d", addr_q.size(), NREAD);
    end
  endtask

  task automatic test_start_ignored();
    int c0;
    bit ok;
    clear_logs();
    ce = 1'b1;
    start_frame(c0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL ign_timeout: got no done, expected done within 200 cycles");
    end
    repeat (30) @(negedge clk);
    checks++;
    if (pix_q.size() !== NPIX || done_q.size() !== 1) begin
      errors++;
      $display("[TB] FAIL ign_count: got %0d pixels %0d done, expected %0d pixels 1 done",
               pix_q.size(), done_q.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < pix_q.size(); i++) begin
      checks++;
      if (pix_q[i] !== exp_pix(i) || (pcyc_q[i] - c0) !== FIRST_REL + i) begin
        errors++;
        $display("[TB] FAIL ign_pix[%0d]: got data=%0h t=%0d, expected data=%0h t=%0d",
                 i, pix_q[i], pcyc_q[i] - c0, exp_pix(i), FIRST_REL + i);
      end
    end
    checks++;
    if (done_q.size() > 0 && (done_q[0] - c0) !== DONE_REL) begin
      errors++;
      $display("[TB] FAIL ign_done: got t=%0d, expected t=%0d", done_q[0] - c0, DONE_REL);
    end
  endtask

  task automatic test_reset_midframe();
    int c0;
    int n;
    bit ok;
    clear_logs();
    ce = 1'b1;
    start_frame(c0);
    n = 0;
    for (int k = 0; k < 50 && n < 6; k++) begin
      @(negedge clk);
      if (dout_vld) n++;
    end
    checks++;
    if (n !== 6) begin
      errors++;
      $display("[TB] FAIL rst_reach: got %0d pixels, expected 6 before reset", n);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_rd_en, dout_vld, row_last, frame_last} !== 6'b0 ||
        dout !== '0 || mem_addr !== '0) begin
      errors++;
      $display("[TB] FAIL rst_outputs: got busy=%b done=%b rd=%b vld=%b rl=%b fl=%b dout=%0h addr=%0h, expected all 0",
               busy, done, mem_rd_en, dout_vld, row_last, frame_last, dout, mem_addr);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (pix_q.size() !== 6 || done_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL rst_abort: got %0d pixels %0d done, expected 6 pixels 0 done",
               pix_q.size(), done_q.size());
    end
    clear_logs();
    start_frame(c0);
    wait_done(1, 200, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || pix_q.size() !== NPIX) begin
      errors++;
      $display("[TB] FAIL rst_restart: got done=%b pixels=%0d, expected 1 and %0d", ok, pix_q.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < pix_q.size(); i++) begin
      checks++;
      if (pix_q[i] !== exp_pix(i) || rl_q[i] !== exp_rl(i) || fl_q[i] !== exp_fl(i) ||
          (pcyc_q[i] - c0) !== FIRST_REL + i) begin
        errors++;
        $display("[TB] FAIL rst_pix[%0d]: got data=%0h rl=%0d fl=%0d t=%0d, expected data=%0h rl=%0d fl=%0d t=%0d",
                 i, pix_q[i], rl_q[i], fl_q[i], pcyc_q[i] - c0, exp_pix(i), exp_rl(i), exp_fl(i), FIRST_REL + i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    int c1;
    int base;
    int j;
    bit seen;
    bit ok;
    clear_logs();
    ce   = 1'b1;
    seen = 1'b0;
    start_frame(c0);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    c1    = cyc;
    start = 1'b0;
    checks++;
    if (!seen || (c1 - c0) !== DONE_REL + 1) begin
      errors++;
      $display("[TB] FAIL b2b_restart: got seen=%b gap=%0d, expected 1 and %0d", seen, c1 - c0, DONE_REL + 1);
    end
    wait_done(2, 200, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || pix_q.size() !== 2 * NPIX || done_q.size() !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d pixels %0d done, expected %0d pixels 2 done",
               pix_q.size(), done_q.size(), 2 * NPIX);
    end
    for (int i = 0; i < 2 * NPIX && i < pix_q.size(); i++) begin
      base = (i < NPIX) ? c0 : c1;
      j    = i % NPIX;
      checks++;
      if (pix_q[i] !== exp_pix(j) || rl_q[i] !== exp_rl(j) || fl_q[i] !== exp_fl(j) ||
          (pcyc_q[i] - base) !== FIRST_REL + j) begin
        errors++;
        $display("[TB] FAIL b2b_pix[%0d]: got data=%0h rl=%0d fl=%0d t=%0d, expected data=%0h rl=%0d fl=%0d t=%0d",
                 i, pix_q[i], rl_q[i], fl_q[i], pcyc_q[i] - base, exp_pix(j), exp_rl(j), exp_fl(j), FIRST_REL + j);
      end
    end
    checks++;
    if (done_q.size() > 1 && (done_q[1] - c1) !== DONE_REL) begin
      errors++;
      $display("[TB] FAIL b2b_done: got t=%0d, expected t=%0d", done_q[1] - c1, DONE_REL);
    end
    checks++;
    if (addr_q.size() !== 2 * NREAD) begin
      errors++;
      $display("[TB] FAIL b2b_reads: got %0d reads, expected %0d", addr_q.size(), 2 * NREAD);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_ce_gap();
    test_start_ignored();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
